// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control sequencer: aluop encodings, CLFZN
// flag positions, PSR update masks and the sequencer state type.
package alu_pkg;

    localparam logic [7:0] ALU_AND = 8'h01;
    localparam logic [7:0] ALU_XOR = 8'h03;
    localparam logic [7:0] ALU_ADD = 8'h05;
    localparam logic [7:0] ALU_SUB = 8'h09;
    localparam logic [7:0] ALU_CMP = 8'h0B;
    localparam logic [7:0] ALU_MOV = 8'h0D;

    localparam int FLG_C = 4;
    localparam int FLG_L = 3;
    localparam int FLG_F = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    function automatic logic [4:0] flag_bit(input int idx);
        return 5'b00001 << idx;
    endfunction

    localparam logic [4:0] MASK_NONE  = 5'b00000;
    localparam logic [4:0] MASK_ARITH = flag_bit(FLG_C) | flag_bit(FLG_F);
    localparam logic [4:0] MASK_CMP   = flag_bit(FLG_L) | flag_bit(FLG_Z) | flag_bit(FLG_N);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction classifier: legality, register-file write-back
// and which PSR flags the ALU result is allowed to update.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [7:0] i_aluop,
    output logic       o_legal,
    output logic       o_writes_rf,
    output logic [4:0] o_flag_mask
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        o_legal     = 1'b0;
        o_writes_rf = 1'b0;
        o_flag_mask = MASK_NONE;
        case (i_aluop)
            ALU_ADD, ALU_SUB: begin
                o_legal     = 1'b1;
                o_writes_rf = 1'b1;
                o_flag_mask = MASK_ARITH;
            end
            ALU_CMP: begin
                o_legal     = 1'b1;
                o_flag_mask = MASK_CMP;
            end
            ALU_AND, ALU_XOR, ALU_MOV: begin
                o_legal     = 1'b1;
                o_writes_rf = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Four-state sequencer (IDLE/DECODE/EXEC/WB) feeding a combinational 16-bit
// ALU and register file, and capturing the ALU flags into the PSR.
module alu_ctrl_fsm
    import alu_pkg::*;
#(
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [15:0]        instr,
    output logic [RADDR_W-1:0] ra_addr,
    output logic [RADDR_W-1:0] rb_addr,
    output logic [7:0]         aluop,
    output logic [3:0]         imm_lo,
    output logic               cin,
    input  logic [4:0]         alu_flags,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [4:0]         psr,
    output logic               done,
    output logic               illegal
);

    state_t               r_state;
    state_t               w_next_state;
    logic [15:0]          r_instr;
    logic [7:0]           r_aluop;
    logic [RADDR_W-1:0]   r_ra_addr;
    logic [RADDR_W-1:0]   r_rb_addr;
    logic [3:0]           r_imm_lo;
    logic [4:0]           r_psr;

    logic [7:0]           w_instr_op;
    logic                 w_legal;
    logic                 w_writes_rf;
    logic [4:0]           w_flag_mask;

    assign w_instr_op = {r_instr[15:12], r_instr[7:4]};

    alu_op_decode u_decode (
        .i_aluop     (w_instr_op),
        .o_legal     (w_legal),
        .o_writes_rf (w_writes_rf),
        .o_flag_mask (w_flag_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        instr_ready  = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        rf_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                illegal      = ~w_legal;
                w_next_state = w_legal ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: begin
                w_next_state = ST_WB;
            end
            ST_WB: begin
                done         = 1'b1;
                rf_we        = w_writes_rf;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ALU-facing fields load only for legal ops, so an illegal instruction
    // leaves the datapath controls exactly as the last legal op left them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr   <= '0;
            r_aluop   <= '0;
            r_ra_addr <= '0;
            r_rb_addr <= '0;
            r_imm_lo  <= '0;
            r_psr     <= '0;
        end else begin
            if (r_state == ST_IDLE && instr_valid) begin
                r_instr <= instr;
            end
            if (r_state == ST_DECODE && w_legal) begin
                r_aluop   <= w_instr_op;
                r_ra_addr <= RADDR_W'(r_instr[11:8]);
                r_rb_addr <= RADDR_W'(r_instr[3:0]);
                r_imm_lo  <= r_instr[3:0];
            end
            if (r_state == ST_EXEC) begin
                r_psr <= (r_psr & ~w_flag_mask) | (alu_flags & w_flag_mask);
            end
        end
    end

    assign aluop    = r_aluop;
    assign ra_addr  = r_ra_addr;
    assign rb_addr  = r_rb_addr;
    assign imm_lo   = r_imm_lo;
    assign rf_waddr = r_ra_addr;
    assign psr      = r_psr;
    assign cin      = 1'b0;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench: behavioural 16x16 register file and 16-bit ALU around the
// sequencer, with hand-computed expectations per scenario.
module tb_alu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  ra_addr, rb_addr, rf_waddr;
    logic [7:0]  aluop;
    logic [3:0]  imm_lo;
    logic        cin;
    logic [4:0]  alu_flags;
    logic        rf_we;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_fsm #(.RADDR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ra_addr     (ra_addr),
        .rb_addr     (rb_addr),
        .aluop       (aluop),
        .imm_lo      (imm_lo),
        .cin         (cin),
        .alu_flags   (alu_flags),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .psr         (psr),
        .done        (done),
        .illegal     (illegal)
    );

    // Register file with a bench-side preload port.
    logic [15:0] rf [16];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_addr = '0;
    logic [15:0] poke_data = '0;
    logic [15:0] alu_res;
    int          we_count = 0;
    int          done_count = 0;

    always @(posedge clk) begin
        if (poke_en)    rf[poke_addr] <= poke_data;
        else if (rf_we) rf[rf_waddr] <= alu_res;
        if (rf_we) we_count <= we_count + 1;
        if (done)  done_count <= done_count + 1;
    end

    // ALU model: A = rf[ra], B = rf[rb]; flags {C,L,F,Z,N} computed for every op.
    logic [15:0] a_op, b_op;
    logic [16:0] sum17, dif17;
    always_comb begin
        a_op  = rf[ra_addr];
        b_op  = rf[rb_addr];
        sum17 = {1'b0, a_op} + {1'b0, b_op};
        dif17 = {1'b0, a_op} - {1'b0, b_op};
        alu_res = 16'h0000;
        case (aluop)
            8'h05:        alu_res = sum17[15:0];
            8'h09, 8'h0B: alu_res = dif17[15:0];
            8'h01:        alu_res = a_op & b_op;
            8'h03:        alu_res = a_op ^ b_op;
            8'h0D:        alu_res = b_op;
            default:      alu_res = 16'h0000;
        endcase
        if (aluop == 8'h05) begin
            alu_flags[4] = sum17[16];
            alu_flags[2] = (a_op[15] == b_op[15]) && (sum17[15] != a_op[15]);
        end else begin
            alu_flags[4] = dif17[16];
            alu_flags[2] = (a_op[15] != b_op[15]) && (dif17[15] != a_op[15]);
        end
        alu_flags[3] = a_op < b_op;
        alu_flags[1] = a_op == b_op;
        alu_flags[0] = $signed(a_op) < $signed(b_op);
    end

    task automatic poke(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = addr; poke_data = data;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Presents one instruction; returns at the negedge inside DECODE.
    task automatic send(input logic [15:0] ins);
        @(negedge clk);
        instr_valid = 1'b1; instr = ins;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
        #1;
        n_checks++;
        if ({instr_ready, rf_we, done, illegal, cin} !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got rdy/we/done/ill/cin=%b want 10000", {instr_ready, rf_we, done, illegal, cin});
        end
        n_checks++;
        if ({aluop, imm_lo, ra_addr, rb_addr, rf_waddr, psr} !== 33'h0) begin
            n_errors++;
            $display("FAIL reset_data: got aluop=%h imm=%h ra=%h rb=%h wa=%h psr=%b want all zero", aluop, imm_lo, ra_addr, rb_addr, rf_waddr, psr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        poke(4'd1, 16'd8);
        poke(4'd2, 16'd9);
        send(16'h0152);
        n_checks++;
        if ({instr_ready, illegal, done} !== 3'b000) begin
            n_errors++; $display("FAIL add_decode: got rdy/ill/done=%b want 000", {instr_ready, illegal, done});
        end
        @(negedge clk);
        n_checks++;
        if ({aluop, ra_addr, rb_addr, imm_lo, cin, rf_we} !== {8'h05, 4'd1, 4'd2, 4'd2, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL add_exec: got aluop=%h ra=%0d rb=%0d imm=%0d cin=%b we=%b want 05 1 2 2 0 0", aluop, ra_addr, rb_addr, imm_lo, cin, rf_we);
        end
        @(negedge clk);
        n_checks++;
        if ({done, rf_we, rf_waddr} !== {1'b1, 1'b1, 4'd1}) begin
            n_errors++; $display("FAIL add_wb: got done=%b we=%b wa=%0d want 1 1 1", done, rf_we, rf_waddr);
        end
        n_checks++;
        if (psr !== 5'b00000) begin
            n_errors++; $display("FAIL add_psr: got %b want 00000", psr);
        end
        @(negedge clk);
        n_checks++;
        if ({done, instr_ready, rf[1]} !== {1'b0, 1'b1, 16'd17}) begin
            n_errors++; $display("FAIL add_result: got done=%b rdy=%b r1=%0d want 0 1 17", done, instr_ready, rf[1]);
        end
    endtask

    task automatic test_sub;
        poke(4'd3, 16'd321);
        poke(4'd4, 16'd300);
        send(16'h0394);
        repeat (2) @(negedge clk);
        n_checks++;
        if ({done, rf_we, rf_waddr} !== {1'b1, 1'b1, 4'd3}) begin
            n_errors++; $display("FAIL sub_wb: got done=%b we=%b wa=%0d want 1 1 3", done, rf_we, rf_waddr);
        end
        @(negedge clk);
        n_checks++;
        if (rf[3] !== 16'd21 || psr !== 5'b00000) begin
            n_errors++; $display("FAIL sub_result: got r3=%0d psr=%b want 21 00000", rf[3], psr);
        end
    endtask

    task automatic test_cmp;
        int we0;
        poke(4'd5, 16'd90);
        poke(4'd6, 16'd90);
        we0 = we_count;
        send(16'h05B6);
        @(negedge clk);
        n_checks++;
        if (aluop !== 8'h0B) begin
            n_errors++; $display("FAIL cmp_aluop: got %h want 0b", aluop);
        end
        @(negedge clk);
        n_checks++;
        if ({done, rf_we} !== 2'b10 || psr !== 5'b00010) begin
            n_errors++; $display("FAIL cmp_wb: got done=%b we=%b psr=%b want 1 0 00010", done, rf_we, psr);
        end
        @(negedge clk);
        n_checks++;
        if (we_count !== we0 || rf[5] !== 16'd90) begin
            n_errors++; $display("FAIL cmp_nowrite: got writes=%0d r5=%0d want 0 90", we_count - we0, rf[5]);
        end
    endtask

    // 0 - 1: ALU raises C, L and N; only C may reach the PSR, Z from CMP holds.
    task automatic test_sub_borrow;
        poke(4'd10, 16'd0);
        poke(4'd11, 16'd1);
        send(16'h0A9B);
        repeat (3) @(negedge clk);
        n_checks++;
        if (rf[10] !== 16'hFFFF || psr !== 5'b10010) begin
            n_errors++; $display("FAIL sub_borrow: got r10=%h psr=%b want ffff 10010", rf[10], psr);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] prog [3];
        int acc [3];
        int k;
        prog = '{16'h0C1D, 16'h0E3F, 16'h07D8};
        acc  = '{-1, -1, -1};
        poke(4'd12, 16'd3);
        poke(4'd13, 16'd1);
        poke(4'd14, 16'd5);
        poke(4'd15, 16'd0);
        poke(4'd7, 16'd0);
        poke(4'd8, 16'd20);
        k = 0;
        instr = prog[0]; instr_valid = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 24 && k < 3; c++) begin
            if (instr_ready) begin
                acc[k] = c;
                k++;
            end
            @(posedge clk);
            #1;
            if (k < 3) instr = prog[k];
            else       instr_valid = 1'b0;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        n_checks++;
        if (k !== 3) begin
            n_errors++; $display("FAIL b2b_accept: got %0d acceptances within budget want 3", k);
        end
        n_checks++;
        if (acc[1] - acc[0] !== 4 || acc[2] - acc[1] !== 4) begin
            n_errors++; $display("FAIL b2b_spacing: got gaps %0d %0d want 4 4", acc[1] - acc[0], acc[2] - acc[1]);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rf[12] !== 16'd1 || rf[14] !== 16'd5 || rf[7] !== 16'd20) begin
            n_errors++; $display("FAIL b2b_results: got and=%0d xor=%0d mov=%0d want 1 5 20", rf[12], rf[14], rf[7]);
        end
        n_checks++;
        if (psr !== 5'b10010) begin
            n_errors++; $display("FAIL b2b_psr: got %b want 10010", psr);
        end
    endtask

    task automatic test_illegal;
        int we0, d0;
        we0 = we_count; d0 = done_count;
        send(16'h0F00);
        n_checks++;
        if ({illegal, instr_ready} !== 2'b10) begin
            n_errors++; $display("FAIL ill_pulse: got ill=%b rdy=%b want 1 0", illegal, instr_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({illegal, instr_ready} !== 2'b01 || aluop !== 8'h0D || psr !== 5'b10010) begin
            n_errors++; $display("FAIL ill_after: got ill=%b rdy=%b aluop=%h psr=%b want 0 1 0d 10010", illegal, instr_ready, aluop, psr);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (we_count !== we0 || done_count !== d0) begin
            n_errors++; $display("FAIL ill_side: got writes=%0d dones=%0d want 0 0", we_count - we0, done_count - d0);
        end
    endtask

    task automatic test_reset_mid;
        int we0, d0;
        we0 = we_count; d0 = done_count;
        send(16'h0152);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({done, rf_we, instr_ready} !== 3'b001 || psr !== 5'b00000 || aluop !== 8'h00 || ra_addr !== 4'd0) begin
            n_errors++; $display("FAIL rst_mid: got done=%b we=%b rdy=%b psr=%b aluop=%h ra=%0d want 0 0 1 00000 00 0", done, rf_we, instr_ready, psr, aluop, ra_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (we_count !== we0 || done_count !== d0 || rf[1] !== 16'd17 || instr_ready !== 1'b1) begin
            n_errors++; $display("FAIL rst_discard: got writes=%0d dones=%0d r1=%0d rdy=%b want 0 0 17 1", we_count - we0, done_count - d0, rf[1], instr_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        test_reset;
        test_add;
        test_sub;
        test_cmp;
        test_sub_borrow;
        test_back_to_back;
        test_illegal;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
